// File: rtl/ifu_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave); one outstanding request at a time.
interface ifu_fetch_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_rvalid_i;
    logic [XLEN-1:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_rvalid_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests
// and registers each returned instruction into the IF/ID register for decode.
module ifu_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    ifu_fetch_if.master imem,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_BUF  = 2'd2,
        ST_DROP = 2'd3
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] addr;
        logic            valid;
    } ifid_t;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] addr;
    } skid_t;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    ifid_t           out_q, out_d;
    skid_t           skid_q, skid_d;
    logic [XLEN-1:0] pc_inc;
    logic            rvalid;

    assign rvalid = imem.imem_rvalid_i;
    assign pc_inc = pc_q + XLEN'(4);

    // Request is a pure function of state; held low while reset is asserted.
    assign imem.imem_req_o  = rst_n && (state_q == ST_REQ);
    assign imem.imem_addr_o = imem.imem_req_o ? pc_q : '0;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        out_d   = out_q;
        skid_d  = skid_q;

        if (jump_en_i) begin
            // Redirect overrides hold; a response still owed by memory must be drained.
            pc_d   = {jump_addr_i[XLEN-1:2], 2'b00};
            out_d  = '{inst: NOP_INST, addr: out_q.addr, valid: 1'b0};
            skid_d = '0;
            case (state_q)
                ST_REQ:  state_d = ST_DROP;
                ST_WAIT: state_d = rvalid ? ST_REQ : ST_DROP;
                ST_BUF:  state_d = ST_REQ;
                ST_DROP: state_d = rvalid ? ST_REQ : ST_DROP;
                default: state_d = ST_REQ;
            endcase
        end else begin
            if (!hold_i) begin
                out_d = '{inst: NOP_INST, addr: out_q.addr, valid: 1'b0};
            end
            case (state_q)
                ST_REQ: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (rvalid) begin
                        pc_d = pc_inc;
                        if (hold_i) begin
                            skid_d  = '{inst: imem.imem_rdata_i, addr: pc_q};
                            state_d = ST_BUF;
                        end else begin
                            out_d   = '{inst: imem.imem_rdata_i, addr: pc_q, valid: 1'b1};
                            state_d = ST_REQ;
                        end
                    end
                end
                ST_BUF: begin
                    if (!hold_i) begin
                        out_d   = '{inst: skid_q.inst, addr: skid_q.addr, valid: 1'b1};
                        skid_d  = '0;
                        state_d = ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (rvalid) begin
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_ADDR;
            out_q   <= '{inst: NOP_INST, addr: '0, valid: 1'b0};
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign inst_o       = out_q.inst;
    assign inst_addr_o  = out_q.addr;
    assign inst_valid_o = out_q.valid;
endmodule
